prom_arb: RTL and testbench
===========================

PROM_ARB -- requirements
Module: prom_arb

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, PROM access wait cycles after enable; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 read request, level.
REQ-005 addr0  input  5  requester 0 PROM address.
REQ-006 ack0  output  1  requester 0 completion, one-cycle pulse.
REQ-007 data0  output  8  requester 0 read data, registered.
REQ-008 req1  input  1  requester 1 read request, level.
REQ-009 addr1  input  5  requester 1 PROM address.
REQ-010 ack1  output  1  requester 1 completion, one-cycle pulse.
REQ-011 data1  output  8  requester 1 read data, registered.
REQ-012 prom_a  output  5  address to 32x8 PROM, registered.
REQ-013 prom_ce_n  output  1  PROM chip enable, active low, registered.
REQ-014 prom_d  input  8  PROM data; high-impedance while prom_ce_n high.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, ACCESS, DONE with a 4-bit wait counter.
REQ-017 IDLE: if req0 or req1 sampled high, SHALL grant one, load prom_a from that requester's addr, drive prom_ce_n low, load counter with WAIT_CYCLES, and enter ACCESS next cycle.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; single request granted immediately.
REQ-019 A last-grant register SHALL update on every grant; reset value = 1, so requester 0 wins the first contended grant.
REQ-020 ACCESS: counter nonzero -> decrement, stay; counter zero -> capture prom_d into granted requester's data register, drive prom_ce_n high, enter DONE.
REQ-021 ACCESS SHALL therefore last WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives one ACCESS cycle.
REQ-022 DONE: granted requester's ack SHALL be high for exactly one cycle; state returns to IDLE next cycle.
REQ-023 Latency: req first sampled high in IDLE at cycle N -> ack high in cycle N+WAIT_CYCLES+2.
REQ-024 prom_a and granted requester SHALL stay constant from grant through DONE; addr changes during ACCESS SHALL be ignored.
REQ-025 Requests SHALL be sampled only in IDLE; requests arriving during ACCESS/DONE wait.
REQ-026 A req still high in the IDLE cycle after its ack SHALL start a new access (requester drops req on ack to avoid repeat).
REQ-027 data0/data1 SHALL hold last captured value until the next capture for that requester; non-granted data register unchanged.
REQ-028 prom_ce_n SHALL be low only during ACCESS; prom_a holds its last value while idle.
REQ-029 ack0 and ack1 SHALL never be high simultaneously.

Reset
REQ-030 reset high at a clock edge SHALL force state IDLE, prom_ce_n=1, prom_a=0, ack0=ack1=0, data0=data1=0, counter=0, last-grant=1, busy=0.
REQ-031 Reset during ACCESS or DONE SHALL abort the access with no ack and no data capture.
REQ-032 Requests held through reset SHALL be granted in the first IDLE cycle after reset deasserts.

Verification
REQ-033 WAIT_CYCLES=2, PROM[5]=8'hA5, req0=1 addr0=5 at cycle 0 -> prom_ce_n low cycles 1-3, prom_a=5, ack0 high cycle 4, data0=8'hA5.
REQ-034 req0 and req1 high from reset release, addr0=1 (8'h11), addr1=2 (8'h22), each dropped on its ack -> ack0 first (data0=8'h11), then ack1 (data1=8'h22); data1 untouched by first access.
REQ-035 Both requests held high continuously -> acks alternate 0,1,0,1; each access spacing WAIT_CYCLES+3 cycles.
REQ-036 WAIT_CYCLES=0, req1 addr1=31 (PROM[31]=8'h3C) -> single ACCESS cycle, ack1 two cycles after sample, data1=8'h3C.
REQ-037 reset asserted in second ACCESS cycle -> next cycle prom_ce_n=1, busy=0, no ack, data registers 0.
REQ-038 addr0 changed 5->9 mid-ACCESS -> prom_a stays 5, captured data is PROM[5].

Source files
------------

// File: rtl/prom_arb.sv
// -----------------------------------------------------------------------------
// prom_arb
// Two-requester round-robin arbiter in front of a 32x8 asynchronous PROM.
// A grant registers the winner's address onto the PROM bus, holds chip enable
// low for WAIT_CYCLES+1 cycles, captures the PROM data into the winner's data
// register and pulses that requester's ack for one cycle.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   req0/req1  level read requests
//   addr0/1    5-bit PROM addresses of each requester
//   ack0/1     one-cycle completion pulses (never both high)
//   data0/1    registered read data, held until that requester's next capture
//   prom_a     registered PROM address
//   prom_ce_n  registered PROM chip enable, active low, low only in ACCESS
//   prom_d     PROM data (floats while prom_ce_n is high)
//   busy       high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module prom_arb #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [4:0] addr0,
  output logic       ack0,
  output logic [7:0] data0,
  input  logic       req1,
  input  logic [4:0] addr1,
  output logic       ack1,
  output logic [7:0] data1,
  output logic [4:0] prom_a,
  output logic       prom_ce_n,
  input  logic [7:0] prom_d,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       gnt;      // requester owning the current access
  logic       last;     // requester granted most recently
  logic       any_req;
  logic       sel;      // requester that wins if a grant happens now

  // Round-robin only matters under contention: the requester not granted
  // last wins; a lone request wins outright.
  always_comb begin
    any_req = req0 | req1;
    sel     = 1'b0;
    if (req0 && req1) begin
      sel = ~last;
    end else begin
      sel = req1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt       <= 1'b0;
      last      <= 1'b1;
      prom_a    <= 5'd0;
      prom_ce_n <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      data0     <= 8'd0;
      data1     <= 8'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= sel;
            last      <= sel;
            prom_a    <= sel ? addr1 : addr0;
            prom_ce_n <= 1'b0;
            cnt       <= WAIT_LD;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last access cycle: PROM output has settled for WAIT_CYCLES+1
            // cycles, so it is captured here and the ack shows up in DONE.
            if (gnt) begin
              data1 <= prom_d;
            end else begin
              data0 <= prom_d;
            end
            prom_ce_n <= 1'b1;
            ack0      <= ~gnt;
            ack1      <= gnt;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          prom_ce_n <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prom_arb.sv
// -----------------------------------------------------------------------------
// tb_prom_arb
// Scoreboard bench for prom_arb. A transaction-level model watches the
// sampled requests at each rising edge, decides grants by round-robin and
// pushes the expected completion (cycle, requester, data) into a queue. A
// separate monitor on the falling edge pops entries as acks appear and checks
// every observable output against the model's view of the arbiter.
// -----------------------------------------------------------------------------
module tb_prom_arb;

  localparam int W = 2;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [4:0] addr0, addr1;
  logic       ack0, ack1;
  logic [7:0] data0, data1;
  logic [4:0] prom_a;
  logic       prom_ce_n;
  logic [7:0] prom_d;
  logic       busy;

  logic [7:0] mem [32];

  prom_arb #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .addr0     (addr0),
    .ack0      (ack0),
    .data0     (data0),
    .req1      (req1),
    .addr1     (addr1),
    .ack1      (ack1),
    .data1     (data1),
    .prom_a    (prom_a),
    .prom_ce_n (prom_ce_n),
    .prom_d    (prom_d),
    .busy      (busy)
  );

  // PROM: asynchronous read; the floating bus is modelled as 0 when disabled.
  assign prom_d = prom_ce_n ? 8'h00 : mem[prom_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         id;
    logic [7:0] data;
    int         ep;
  } exp_t;

  exp_t q[$];

  // Model state, owned by the model process.
  int         cyc     = 0;
  int         free_at = 0;   // first cycle in which the arbiter can grant again
  int         epoch   = 0;   // bumped on every reset edge
  bit         m_last  = 1'b1;
  logic [4:0] m_a     = 5'd0;

  // Counters, owned by the monitor process.
  int nchecks = 0;
  int nfail   = 0;

  // ---------------- reference model ----------------
  initial begin
    forever begin
      @(posedge clk);
      begin
        int   cur;
        bit   id;
        exp_t e;
        cur = cyc;
        if (reset) begin
          epoch   = epoch + 1;
          m_last  = 1'b1;
          m_a     = 5'd0;
          free_at = cur + 1;
        end else if (cur >= free_at && (req0 || req1)) begin
          if (req0 && req1) id = !m_last;
          else              id = req1;
          m_last  = id;
          m_a     = id ? addr1 : addr0;
          e.cyc   = cur + W + 2;
          e.id    = id;
          e.data  = mem[m_a];
          e.ep    = epoch;
          q.push_back(e);
          free_at = cur + W + 3;
        end
        cyc = cur + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nchecks++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, want);
    end
  endtask

  initial begin
    int         seen_ep;
    logic [7:0] exp_d0, exp_d1;
    exp_t       e;
    seen_ep = 0;
    exp_d0  = 8'h00;
    exp_d1  = 8'h00;
    forever begin
      @(negedge clk);
      if (epoch != 0) begin
        if (epoch != seen_ep) begin
          seen_ep = epoch;
          exp_d0  = 8'h00;
          exp_d1  = 8'h00;
        end
        // Accesses aborted by reset never complete.
        while (q.size() != 0 && q[0].ep != epoch) void'(q.pop_front());
        if (q.size() != 0 && q[0].cyc < cyc) begin
          chk("ack_missing", 32'(q[0].cyc), 32'(cyc));
          e = q.pop_front();
          if (e.id) exp_d1 = e.data; else exp_d0 = e.data;
        end
        chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (ack0 || ack1) begin
          if (q.size() == 0) begin
            chk("ack_unexpected", 32'(ack1), 32'(ack0));
          end else begin
            e = q.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("ack_id", 32'(ack1), 32'(e.id));
            if (e.id) exp_d1 = e.data; else exp_d0 = e.data;
          end
        end
        chk("data0", 32'(data0), 32'(exp_d0));
        chk("data1", 32'(data1), 32'(exp_d1));
        chk("busy", 32'(busy), 32'(cyc < free_at));
        chk("prom_ce_n", 32'(prom_ce_n), 32'(!(cyc + 1 < free_at)));
        chk("prom_a", 32'(prom_a), 32'(m_a));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Requesters drop their request on seeing their ack.
  task automatic run_drop(input int n);
    repeat (n) begin
      step();
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = 5'd0;
    addr1 = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(1, 255));
    mem[1]  = 8'h11;
    mem[2]  = 8'h22;
    mem[5]  = 8'hA5;
    mem[9]  = 8'h99;
    mem[31] = 8'h3C;
    repeat (3) step();

    // Single request, address 5.
    reset = 1'b0;
    step();
    req0  = 1'b1;
    addr0 = 5'd5;
    run_drop(W + 4);

    // Address change mid-access must be ignored.
    req0  = 1'b1;
    addr0 = 5'd5;
    step();
    step();
    addr0 = 5'd9;
    run_drop(W + 4);

    // Both requests held through reset; requester 0 wins first.
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 5'd1;
    addr1 = 5'd2;
    step();
    step();
    reset = 1'b0;
    run_drop(2 * (W + 3) + 2);

    // Continuous contention: acks alternate.
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 5'd31;
    addr1 = 5'd9;
    repeat (6 * (W + 3)) step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (W + 4) step();

    // Reset in the second ACCESS cycle aborts the access.
    req0  = 1'b1;
    addr0 = 5'd7;
    step();
    step();
    reset = 1'b1;
    req0  = 1'b0;
    step();
    reset = 1'b0;
    repeat (4) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      addr0 = 5'($urandom_range(0, 31));
      addr1 = 5'($urandom_range(0, 31));
      step();
    end

    // Drain: any expected ack that never appears is flagged as missing.
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (W + 8) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
